// File: rtl/mod_mul_arb.sv
// mod_mul_arb: two-requester front end that time-shares a single modular
// multiplier. Each transaction runs IDLE -> CALC -> DONE -> IDLE.
// Optional build macro MOD_MUL_ARB_RR_EN selects round-robin arbitration;
// without it req0 always wins a simultaneous request.

// Combinational modular multiplier: c = (a * b) mod q.
// q = 3329 when select=1, q = 8380417 when select=0.
module mod_mul #(
   parameter int unsigned DW = 23
) (
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          select,
   output logic [DW-1:0] c
);
   localparam int unsigned PW = 2 * DW;
   localparam logic [PW-1:0] Q_SMALL = PW'(3329);
   localparam logic [PW-1:0] Q_BIG   = PW'(8380417);

   logic [PW-1:0] prod;

   // Full-width product reduced by whichever modulus is selected.
   always_comb begin
      prod = PW'(a) * PW'(b);
      c    = select ? DW'(prod % Q_SMALL) : DW'(prod % Q_BIG);
   end
endmodule

module mod_mul_arb #(
   parameter int unsigned DW = 23
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req0_valid_i,
   output logic          req0_ready_o,
   input  logic [DW-1:0] req0_a_i,
   input  logic [DW-1:0] req0_b_i,
   input  logic          req0_select_i,
   input  logic          req1_valid_i,
   output logic          req1_ready_o,
   input  logic [DW-1:0] req1_a_i,
   input  logic [DW-1:0] req1_b_i,
   input  logic          req1_select_i,
   output logic          rsp0_valid_o,
   input  logic          rsp0_ready_i,
   output logic          rsp1_valid_o,
   input  logic          rsp1_ready_i,
   output logic [DW-1:0] rsp_c_o,
   output logic          rsp_err_o,
   output logic          busy_o
);
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t        state;
   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic          op_select;
   logic          owner;
   logic          grant0;
   logic          grant1;
   logic          rsp_accept;
   logic [DW-1:0] mul_c;
   logic [DW-1:0] c_q;
   logic          err_q;
   logic          rsp0_valid;
   logic          rsp1_valid;
   logic          busy;
`ifdef MOD_MUL_ARB_RR_EN
   // ID of the requester granted most recently; 1 after reset so req0 wins first.
   logic          last_grant;
`endif

   mod_mul #(.DW(DW)) u_mod_mul (
      .a      (op_a),
      .b      (op_b),
      .select (op_select),
      .c      (mul_c)
   );

   // Grant decision; only offered in IDLE and never while reset is asserted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !rst_i) begin
`ifdef MOD_MUL_ARB_RR_EN
         if (req0_valid_i && req1_valid_i) begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = req0_valid_i;
            grant1 = req1_valid_i;
         end
`else
         grant0 = req0_valid_i;
         grant1 = req1_valid_i && !req0_valid_i;
`endif
      end
   end

   // Response handshake from the owning requester only.
   always_comb begin
      rsp_accept = owner ? rsp1_ready_i : rsp0_ready_i;
   end

   // Transaction FSM with registered result, error flag, valids and busy.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         op_select  <= 1'b0;
         owner      <= 1'b0;
         c_q        <= '0;
         err_q      <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         busy       <= 1'b0;
`ifdef MOD_MUL_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_a      <= grant1 ? req1_a_i : req0_a_i;
                  op_b      <= grant1 ? req1_b_i : req0_b_i;
                  op_select <= grant1 ? req1_select_i : req0_select_i;
                  owner     <= grant1;
                  busy      <= 1'b1;
                  state     <= CALC;
`ifdef MOD_MUL_ARB_RR_EN
                  last_grant <= grant1;
`endif
               end
            end
            CALC: begin
               c_q        <= mul_c;
               err_q      <= op_select && ((|op_a[DW-1:12]) || (|op_b[DW-1:12]));
               rsp0_valid <= !owner;
               rsp1_valid <= owner;
               state      <= DONE;
            end
            DONE: begin
               if (rsp_accept) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign req0_ready_o = grant0;
   assign req1_ready_o = grant1;
   assign rsp0_valid_o = rsp0_valid;
   assign rsp1_valid_o = rsp1_valid;
   assign rsp_c_o      = c_q;
   assign rsp_err_o    = err_q;
   assign busy_o       = busy;
endmodule

// File: tb/tb_mod_mul_arb.sv
// Directed self-checking bench for mod_mul_arb. Honors MOD_MUL_ARB_RR_EN
// for the expected grant order in the contention scenario.
module tb_mod_mul_arb;
   localparam int unsigned DW = 23;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req0_valid_i = 1'b0;
   logic          req0_ready_o;
   logic [DW-1:0] req0_a_i = '0;
   logic [DW-1:0] req0_b_i = '0;
   logic          req0_select_i = 1'b0;
   logic          req1_valid_i = 1'b0;
   logic          req1_ready_o;
   logic [DW-1:0] req1_a_i = '0;
   logic [DW-1:0] req1_b_i = '0;
   logic          req1_select_i = 1'b0;
   logic          rsp0_valid_o;
   logic          rsp0_ready_i = 1'b0;
   logic          rsp1_valid_o;
   logic          rsp1_ready_i = 1'b0;
   logic [DW-1:0] rsp_c_o;
   logic          rsp_err_o;
   logic          busy_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mod_mul_arb #(.DW(DW)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .req0_valid_i  (req0_valid_i),
      .req0_ready_o  (req0_ready_o),
      .req0_a_i      (req0_a_i),
      .req0_b_i      (req0_b_i),
      .req0_select_i (req0_select_i),
      .req1_valid_i  (req1_valid_i),
      .req1_ready_o  (req1_ready_o),
      .req1_a_i      (req1_a_i),
      .req1_b_i      (req1_b_i),
      .req1_select_i (req1_select_i),
      .rsp0_valid_o  (rsp0_valid_o),
      .rsp0_ready_i  (rsp0_ready_i),
      .rsp1_valid_o  (rsp1_valid_o),
      .rsp1_ready_i  (rsp1_ready_i),
      .rsp_c_o       (rsp_c_o),
      .rsp_err_o     (rsp_err_o),
      .busy_o        (busy_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      req0_valid_i = 1'b1;
      req1_valid_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (req0_ready_o !== 1'b0) begin failures++; $display("FAIL rst_req0_ready got=%0b exp=0", req0_ready_o); end
      checks++; if (req1_ready_o !== 1'b0) begin failures++; $display("FAIL rst_req1_ready got=%0b exp=0", req1_ready_o); end
      checks++; if ({rsp0_valid_o, rsp1_valid_o} !== 2'b00) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=00", {rsp0_valid_o, rsp1_valid_o}); end
      checks++; if (rsp_c_o !== 23'h0) begin failures++; $display("FAIL rst_rsp_c got=%h exp=0", rsp_c_o); end
      checks++; if ({rsp_err_o, busy_o} !== 2'b00) begin failures++; $display("FAIL rst_err_busy got=%b exp=00", {rsp_err_o, busy_o}); end
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   task automatic test_req0_basic();
      req0_valid_i = 1'b1; req0_select_i = 1'b1; req0_a_i = 23'hEA1; req0_b_i = 23'h6C6;
      rsp0_ready_i = 1'b1;
      @(negedge clk);
      checks++; if ({req0_ready_o, req1_ready_o, busy_o} !== 3'b100) begin failures++; $display("FAIL basic_grant got=%b exp=100", {req0_ready_o, req1_ready_o, busy_o}); end
      tick();                       // T+1: CALC
      req0_valid_i = 1'b0;
      checks++; if ({rsp0_valid_o, busy_o, req0_ready_o} !== 3'b010) begin failures++; $display("FAIL basic_calc got=%b exp=010", {rsp0_valid_o, busy_o, req0_ready_o}); end
      tick();                       // T+2: DONE
      checks++; if ({rsp0_valid_o, rsp1_valid_o} !== 2'b10) begin failures++; $display("FAIL basic_valid got=%b exp=10", {rsp0_valid_o, rsp1_valid_o}); end
      checks++; if (rsp_c_o !== 23'h8E8) begin failures++; $display("FAIL basic_c got=%h exp=8e8", rsp_c_o); end
      checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL basic_err got=%0b exp=0", rsp_err_o); end
      tick();                       // back in IDLE
      checks++; if ({rsp0_valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL basic_idle got=%b exp=00", {rsp0_valid_o, busy_o}); end
      checks++; if (rsp_c_o !== 23'h8E8) begin failures++; $display("FAIL basic_c_hold got=%h exp=8e8", rsp_c_o); end
   endtask

   task automatic test_back_to_back();
      int got;
      int exp_id;
      logic [DW-1:0] exp_c;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      req0_valid_i = 1'b1; req0_select_i = 1'b1; req0_a_i = 23'h0B7; req0_b_i = 23'hABC;
      req1_valid_i = 1'b1; req1_select_i = 1'b1; req1_a_i = 23'h7B6; req1_b_i = 23'hC92;
      rsp0_ready_i = 1'b1;
      rsp1_ready_i = 1'b1;
      for (int g = 0; g < 4; g++) begin
`ifdef MOD_MUL_ARB_RR_EN
         exp_id = g % 2;
`else
         exp_id = 0;
`endif
         exp_c = (exp_id == 0) ? 23'h0CD : 23'h258;
         got = -1;
         for (int k = 0; k < 8 && got < 0; k++) begin
            @(negedge clk);
            if (req0_ready_o && !req1_ready_o) got = 0;
            else if (req1_ready_o && !req0_ready_o) got = 1;
         end
         checks++; if (got != exp_id) begin failures++; $display("FAIL b2b_grant%0d got=%0d exp=%0d", g, got, exp_id); end
         @(negedge clk);            // CALC
         @(negedge clk);            // DONE
         checks++; if ({rsp0_valid_o, rsp1_valid_o} !== ((exp_id == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL b2b_valid%0d got=%b owner=%0d", g, {rsp0_valid_o, rsp1_valid_o}, exp_id); end
         checks++; if (rsp_c_o !== exp_c) begin failures++; $display("FAIL b2b_c%0d got=%h exp=%h", g, rsp_c_o, exp_c); end
      end
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] held;
      req0_valid_i = 1'b1; req0_select_i = 1'b1; req0_a_i = 23'hEA1; req0_b_i = 23'h6C6;
      req1_valid_i = 1'b1; req1_select_i = 1'b0; req1_a_i = 23'h57882B; req1_b_i = 23'h7F0FEA;
      rsp0_ready_i = 1'b0;
      rsp1_ready_i = 1'b1;          // non-owner ready must be ignored
      @(negedge clk);
      checks++; if ({req0_ready_o, req1_ready_o} !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", {req0_ready_o, req1_ready_o}); end
      tick();
      req0_valid_i = 1'b0;
      tick();                       // DONE
      held = 23'h8E8;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++; if ({rsp0_valid_o, rsp1_valid_o, busy_o, req1_ready_o} !== 4'b1010) begin failures++; $display("FAIL bp_hold%0d got=%b exp=1010", i, {rsp0_valid_o, rsp1_valid_o, busy_o, req1_ready_o}); end
         checks++; if (rsp_c_o !== held) begin failures++; $display("FAIL bp_c%0d got=%h exp=%h", i, rsp_c_o, held); end
      end
      tick();
      rsp0_ready_i = 1'b1;
      tick();                       // IDLE, req1 still waiting
      checks++; if ({rsp0_valid_o, busy_o, req1_ready_o} !== 3'b001) begin failures++; $display("FAIL bp_release got=%b exp=001", {rsp0_valid_o, busy_o, req1_ready_o}); end
      checks++; if (rsp_c_o !== held) begin failures++; $display("FAIL bp_c_retain got=%h exp=%h", rsp_c_o, held); end
      tick();                       // req1 handshake happened; CALC
      req1_valid_i = 1'b0;
      tick();                       // DONE for req1
      checks++; if ({rsp0_valid_o, rsp1_valid_o} !== 2'b01) begin failures++; $display("FAIL req1_valid got=%b exp=01", {rsp0_valid_o, rsp1_valid_o}); end
      checks++; if (rsp_c_o !== 23'h324294) begin failures++; $display("FAIL req1_c got=%h exp=324294", rsp_c_o); end
      checks++; if (rsp_err_o !== 1'b0) begin failures++; $display("FAIL req1_err got=%0b exp=0", rsp_err_o); end
      tick();
      checks++; if ({rsp1_valid_o, busy_o} !== 2'b00) begin failures++; $display("FAIL req1_idle got=%b exp=00", {rsp1_valid_o, busy_o}); end
   endtask

   task automatic test_width_err();
      req0_valid_i = 1'b1; req0_select_i = 1'b1; req0_a_i = 23'h1000; req0_b_i = 23'h001;
      rsp0_ready_i = 1'b1;
      tick();
      req0_valid_i = 1'b0;
      tick();
      checks++; if ({rsp0_valid_o, rsp_err_o} !== 2'b11) begin failures++; $display("FAIL err_flag got=%b exp=11", {rsp0_valid_o, rsp_err_o}); end
      checks++; if (rsp_c_o !== 23'h2FF) begin failures++; $display("FAIL err_c got=%h exp=2ff", rsp_c_o); end
      tick();
   endtask

   task automatic test_reset_in_calc();
      req1_valid_i = 1'b1; req1_select_i = 1'b1; req1_a_i = 23'h0B7; req1_b_i = 23'hABC;
      rsp1_ready_i = 1'b0;
      tick();                       // CALC
      req1_valid_i = 1'b0;
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      checks++; if ({busy_o, rsp0_valid_o, rsp1_valid_o} !== 3'b000) begin failures++; $display("FAIL rcalc_idle got=%b exp=000", {busy_o, rsp0_valid_o, rsp1_valid_o}); end
      checks++; if (rsp_c_o !== 23'h0) begin failures++; $display("FAIL rcalc_c got=%h exp=0", rsp_c_o); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if ({rsp0_valid_o, rsp1_valid_o} !== 2'b00) begin failures++; $display("FAIL rcalc_novalid%0d got=%b exp=00", i, {rsp0_valid_o, rsp1_valid_o}); end
      end
      tick();
      req0_valid_i = 1'b1; req0_select_i = 1'b1; req0_a_i = 23'h0B7; req0_b_i = 23'hABC;
      rsp0_ready_i = 1'b1;
      tick();
      req0_valid_i = 1'b0;
      tick();
      checks++; if ({rsp0_valid_o, rsp1_valid_o} !== 2'b10) begin failures++; $display("FAIL rcalc_after_valid got=%b exp=10", {rsp0_valid_o, rsp1_valid_o}); end
      checks++; if (rsp_c_o !== 23'h0CD) begin failures++; $display("FAIL rcalc_after_c got=%h exp=0cd", rsp_c_o); end
      tick();
   endtask

   initial begin
      test_reset();
      test_req0_basic();
      test_back_to_back();
      test_backpressure();
      test_width_err();
      test_reset_in_calc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mod_mul_arb.md
MOD_MUL_ARB -- requirements
Module: mod_mul_arb

Interface
REQ-001 SHALL have parameter: DW, 23, operand/result width; SHALL equal the mod_mul port width.
REQ-002 SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk_i.
REQ-003 Ports SHALL be as follows:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- reqN_valid_i  input  1  request N (N=0,1) operands valid.
- reqN_ready_o  output  1  request N accepted this cycle.
- reqN_a_i  input  DW  operand a for request N.
- reqN_b_i  input  DW  operand b for request N.
- reqN_select_i  input  1  1=12-bit modulus 3329, 0=23-bit modulus 8380417.
- rspN_valid_o  output  1  result for requester N valid.
- rspN_ready_i  input  1  requester N accepts result.
- rsp_c_o  output  DW  result, shared by both response ports.
- rsp_err_o  output  1  width error flag for the presented result.
- busy_o  output  1  high whenever state is not IDLE.

Function
REQ-004 SHALL instantiate exactly one mod_mul and time-share it between the two requesters.
REQ-005 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-006 IDLE behaviour:
- SHALL assert reqN_ready_o combinationally only for the arbitration winner among the valid requests, and only in IDLE.
- On valid&ready, SHALL capture a, b, select and owner ID into operand registers, then go to CALC.
- With no request valid, SHALL stay in IDLE.
REQ-007 CALC SHALL register the mod_mul output into rsp_c_o, compute rsp_err_o, and go to DONE (one cycle).
REQ-008 DONE behaviour:
- SHALL assert rspN_valid_o only for the owner.
- SHALL hold rsp_c_o and rsp_err_o stable until rspN_ready_i is sampled high.
- SHALL then go to IDLE; SHALL stay in DONE indefinitely under backpressure.
REQ-009 Latency SHALL be: request handshake at cycle T, rspN_valid_o high from T+2; minimum issue interval SHALL be 3 cycles.
REQ-010 The non-owner's rspN_ready_i SHALL be ignored; reqN_ready_o SHALL be 0 in CALC and DONE.
REQ-011 A request SHALL NOT be dropped: a losing or stalled valid request SHALL wait with ready low until granted.
REQ-012 rsp_err_o SHALL be 1 when the captured select=1 and a[22:12] or b[22:12] is nonzero; the result SHALL still be passed through unchanged.
REQ-013 rsp_c_o SHALL retain its last value after the response handshake, until the next CALC.

Reset
REQ-014 On rst_i=1, the block SHALL set:
- state=IDLE.
- reqN_ready_o=0 and rspN_valid_o=0.
- rsp_c_o=0, rsp_err_o=0, busy_o=0.
- last-grant register=1, so req0 wins first.
REQ-015 Reset asserted in CALC or DONE SHALL discard the pending result without any response handshake.

Configuration
REQ-016 Macro MOD_MUL_ARB_RR_EN, when defined:
- Arbitration SHALL be round-robin: with both requests valid, the requester not granted last SHALL win.
- The last-grant register SHALL update on every request handshake.
REQ-017 Without MOD_MUL_ARB_RR_EN, arbitration SHALL be fixed priority with req0 winning; the last-grant register SHALL be absent.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- req0 with select=1, a=0xEA1, b=0x6C6 -> rsp0_valid_o at T+2, rsp_c_o=0x8E8, rsp_err_o=0.
- req1 with select=0, a=0x57882B, b=0x7F0FEA -> rsp1_valid_o only, rsp_c_o=0x324294; rsp0_valid_o stays 0.
- Both valid every cycle: req0 {1, 0xB7, 0xABC}, req1 {1, 0x7B6, 0xC92}.
  - With RR_EN: grants alternate 0,1,0,1, results 0xCD and 0x258.
  - Without RR_EN: req0 is always granted.
- rsp0_ready_i held low for 10 cycles after a result -> state stays DONE, rsp_c_o stable, busy_o=1, req1 ready stays 0.
  - Raising rsp0_ready_i returns to IDLE next cycle.
- select=1, a=0x1000, b=0x001 -> rsp_err_o=1.
- rst_i pulsed in CALC -> next cycle IDLE, no rspN_valid_o; the following request completes normally.
